// File: rtl/mat_mult_seq.sv
// Sequencer for C = A x B on 5x5 signed 8-bit matrices: one row/column pair is fed
// to the combinational inner-product unit per cycle, results and overflow flags are stored.

module mat_mult_ip #(
  parameter int DIM = 5,
  parameter int DW  = 8
) (
  input  logic [DIM*DW-1:0] lin,
  input  logic [DIM*DW-1:0] col,
  output logic [DW-1:0]     n_out,
  output logic              ovf
);
  localparam int LW = DIM * DW;
  localparam int SW = 2 * DW + 3;

  logic signed [2*DW-1:0] prod [DIM];
  logic signed [SW-1:0]   sum;
  logic [SW-DW:0]         upper;

  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_prod
      assign prod[gi] = $signed(lin[LW-1-gi*DW -: DW]) * $signed(col[LW-1-gi*DW -: DW]);
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int k = 0; k < DIM; k++) begin
      sum = sum + SW'(prod[k]);
    end
  end

  // In range exactly when every bit from the 8-bit sign position upward agrees.
  assign upper = sum[SW-1:DW-1];
  assign n_out = sum[DW-1:0];
  assign ovf   = ~((&upper) | ~(|upper));
endmodule

module mat_mult_seq #(
  parameter int DIM = 5,
  parameter int DW  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DIM*DIM*DW-1:0]  mat_a,
  input  logic [DIM*DIM*DW-1:0]  mat_b,
  output logic                   busy,
  output logic                   done,
  output logic [DIM*DIM*DW-1:0]  mat_c,
  output logic [DIM*DIM-1:0]     ovf_map,
  output logic                   ovf_any
);
  localparam int NEL = DIM * DIM;
  localparam int LW  = DIM * DW;
  localparam int MW  = NEL * DW;
  localparam logic [4:0] LAST_IDX = 5'(NEL - 1);
  localparam logic [2:0] LAST_RC  = 3'(DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [MW-1:0]   a_reg, b_reg;
  logic [MW-1:0]   b_cols;
  logic [4:0]      idx_reg;
  logic [2:0]      row_reg, col_reg;
  logic [DW-1:0]   c_reg [NEL];
  logic [NEL-1:0]  ovf_reg;
  logic [LW-1:0]   a_rows [DIM];
  logic [LW-1:0]   b_col_sel [DIM];
  logic [LW-1:0]   lin, col;
  logic [DW-1:0]   n_out;
  logic            ovf;
  logic            accept, write_en;

  // b_cols is B transposed, so column c is a contiguous 40-bit slice with (0,c) on top.
  genvar gi, gj;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_rc
      assign a_rows[gi]    = a_reg[MW-1-gi*LW -: LW];
      assign b_col_sel[gi] = b_cols[MW-1-gi*LW -: LW];
      for (gj = 0; gj < DIM; gj++) begin : g_tr
        assign b_cols[MW-1-(gi*DIM+gj)*DW -: DW] = b_reg[MW-1-(gj*DIM+gi)*DW -: DW];
      end
    end
    for (gi = 0; gi < NEL; gi++) begin : g_out
      assign mat_c[MW-1-gi*DW -: DW] = c_reg[gi];
    end
  endgenerate

  assign lin = a_rows[row_reg];
  assign col = b_col_sel[col_reg];

  mat_mult_ip #(.DIM(DIM), .DW(DW)) u_ip (
    .lin   (lin),
    .col   (col),
    .n_out (n_out),
    .ovf   (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    write_en   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (idx_reg > LAST_IDX) begin
          state_next = S_IDLE;
        end else begin
          write_en = 1'b1;
          if (idx_reg == LAST_IDX) state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      idx_reg <= '0;
      row_reg <= '0;
      col_reg <= '0;
      ovf_reg <= '0;
      for (int k = 0; k < NEL; k++) c_reg[k] <= '0;
    end else if (accept) begin
      a_reg   <= mat_a;
      b_reg   <= mat_b;
      idx_reg <= '0;
      row_reg <= '0;
      col_reg <= '0;
      ovf_reg <= '0;
    end else if (write_en) begin
      c_reg[idx_reg]   <= n_out;
      ovf_reg[idx_reg] <= ovf;
      idx_reg          <= idx_reg + 5'd1;
      if (col_reg == LAST_RC) begin
        col_reg <= '0;
        row_reg <= row_reg + 3'd1;
      end else begin
        col_reg <= col_reg + 3'd1;
      end
    end
  end

  assign ovf_map = ovf_reg;
  assign ovf_any = |ovf_reg;
endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq: reference model pushes expected results to a
// scoreboard at start, popped and compared when done is observed.

module tb_mat_mult_seq;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [199:0] mat_a = '0;
  logic [199:0] mat_b = '0;
  logic         busy, done, ovf_any;
  logic [199:0] mat_c;
  logic [24:0]  ovf_map;

  int errors = 0;
  int checks = 0;
  logic [199:0] exp_c_q [$];
  logic [24:0]  exp_ovf_q [$];

  mat_mult_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mat_a   (mat_a),
    .mat_b   (mat_b),
    .busy    (busy),
    .done    (done),
    .mat_c   (mat_c),
    .ovf_map (ovf_map),
    .ovf_any (ovf_any)
  );

  always #5 clk = ~clk;

  function automatic int el(input logic [199:0] m, input int r, input int c);
    logic signed [7:0] v;
    v = m[199-8*(5*r+c) -: 8];
    return int'(v);
  endfunction

  function automatic logic [199:0] put(input logic [199:0] m, input int r, input int c,
                                       input logic [7:0] v);
    logic [199:0] t;
    t = m;
    t[199-8*(5*r+c) -: 8] = v;
    return t;
  endfunction

  task automatic push_expect(input logic [199:0] a, input logic [199:0] b);
    logic [199:0] ec;
    logic [24:0]  eo;
    int s;
    ec = '0;
    eo = '0;
    for (int r = 0; r < 5; r++) begin
      for (int cc = 0; cc < 5; cc++) begin
        s = 0;
        for (int k = 0; k < 5; k++) s = s + el(a, r, k) * el(b, k, cc);
        ec[199-8*(5*r+cc) -: 8] = s[7:0];
        eo[5*r+cc] = (s > 127) || (s < -128);
      end
    end
    exp_c_q.push_back(ec);
    exp_ovf_q.push_back(eo);
  endtask

  // Pulses start once; n counts negedges after the accepting edge (n=25 is cycle t+26).
  task automatic run_op(input string name, input logic [199:0] a, input logic [199:0] b,
                        input int chg_at, input int restart_at);
    int busy_cnt, done_cnt, done_n;
    logic [199:0] ec;
    logic [24:0]  eo;
    mat_a = a;
    mat_b = b;
    push_expect(a, b);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    done_n   = -1;
    for (int n = 0; n < 40; n++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (n == chg_at) mat_a = ~mat_a;
      start = (n == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
    ec = exp_c_q.pop_front();
    eo = exp_ovf_q.pop_front();
    $display("run %s: done_at=%0d done_pulses=%0d busy_cycles=%0d ovf_map=%h",
             name, done_n, done_cnt, busy_cnt, ovf_map);
    checks++;
    if (done_n !== 25) begin errors++; $display("FAIL %s done_cycle got %0d want 25", name, done_n); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", name, done_cnt); end
    checks++;
    if (busy_cnt !== 25) begin errors++; $display("FAIL %s busy_cycles got %0d want 25", name, busy_cnt); end
    checks++;
    if (mat_c !== ec) begin errors++; $display("FAIL %s mat_c got %h want %h", name, mat_c, ec); end
    checks++;
    if (ovf_map !== eo) begin errors++; $display("FAIL %s ovf_map got %h want %h", name, ovf_map, eo); end
    checks++;
    if (ovf_any !== (|eo)) begin errors++; $display("FAIL %s ovf_any got %b want %b", name, ovf_any, |eo); end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ovf_any} !== 3'b000) begin
      errors++; $display("FAIL reset flags got %b want 000", {busy, done, ovf_any});
    end
    checks++;
    if (mat_c !== '0) begin errors++; $display("FAIL reset mat_c got %h want 0", mat_c); end
    checks++;
    if (ovf_map !== '0) begin errors++; $display("FAIL reset ovf_map got %h want 0", ovf_map); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("reset: busy=%b done=%b ovf_any=%b", busy, done, ovf_any);
  endtask

  task automatic test_identity();
    logic [199:0] a, b;
    a = '0;
    b = '0;
    for (int r = 0; r < 5; r++) begin
      a = put(a, r, r, 8'd1);
      for (int c = 0; c < 5; c++) b = put(b, r, c, 8'(c + 1));
    end
    run_op("identity", a, b, -1, -1);
    checks++;
    if (mat_c !== b) begin errors++; $display("FAIL identity mat_c got %h want %h", mat_c, b); end
  endtask

  task automatic test_ones();
    logic [199:0] ones, fives;
    ones  = {25{8'h01}};
    fives = {25{8'h05}};
    run_op("ones", ones, ones, -1, -1);
    checks++;
    if (mat_c !== fives) begin errors++; $display("FAIL ones mat_c got %h want %h", mat_c, fives); end
  endtask

  task automatic test_negative();
    logic [199:0] a, b, want;
    a = '0;
    b = '0;
    a[199 -: 40] = {5{8'hFF}};
    b = put(b, 0, 0, 8'd2);
    b = put(b, 1, 0, 8'd3);
    b = put(b, 2, 0, 8'hFE);
    b = put(b, 3, 0, 8'd1);
    b = put(b, 4, 0, 8'hFE);
    want = '0;
    want[199 -: 8] = 8'hFE;
    run_op("negative", a, b, -1, -1);
    checks++;
    if (mat_c !== want) begin errors++; $display("FAIL negative mat_c got %h want %h", mat_c, want); end
  endtask

  task automatic test_overflow();
    logic [199:0] m, want;
    m    = {25{8'h7F}};
    want = {25{8'h05}};
    run_op("overflow", m, m, -1, -1);
    checks++;
    if (mat_c !== want) begin errors++; $display("FAIL overflow mat_c got %h want %h", mat_c, want); end
    checks++;
    if (ovf_map !== 25'h1FFFFFF) begin
      errors++; $display("FAIL overflow ovf_map got %h want 1ffffff", ovf_map);
    end
  endtask

  task automatic test_back_to_back();
    logic [199:0] a, b;
    for (int w = 0; w < 7; w++) begin
      a[w*32 +: 32] = $urandom;
      b[w*32 +: 32] = $urandom;
    end
    run_op("restart_ignored", a, b, 4, 9);
  endtask

  task automatic test_reset_mid();
    int done_seen;
    logic [199:0] a, b;
    for (int w = 0; w < 7; w++) begin
      a[w*32 +: 32] = $urandom;
      b[w*32 +: 32] = $urandom;
    end
    mat_a = a;
    mat_b = b;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 11; n++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_mid flags got %b want 00", {busy, done}); end
    checks++;
    if (mat_c !== '0) begin errors++; $display("FAIL reset_mid mat_c got %h want 0", mat_c); end
    checks++;
    if (ovf_map !== '0) begin errors++; $display("FAIL reset_mid ovf_map got %h want 0", ovf_map); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    $display("reset_mid: done_pulses=%0d busy=%b", done_seen, busy);
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL reset_mid done_pulses got %0d want 0", done_seen); end
    run_op("after_reset", b, a, -1, -1);
  endtask

  task automatic test_start_held();
    logic [199:0] a, b, ec;
    logic [24:0]  eo;
    int done_at [2];
    int nd;
    for (int w = 0; w < 7; w++) begin
      a[w*32 +: 32] = $urandom;
      b[w*32 +: 32] = $urandom;
    end
    mat_a = a;
    mat_b = b;
    push_expect(a, b);
    push_expect(a, b);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    nd = 0;
    for (int n = 0; n < 80 && nd < 2; n++) begin
      if (done) begin
        done_at[nd] = n;
        ec = exp_c_q.pop_front();
        eo = exp_ovf_q.pop_front();
        $display("held run %0d: done_at=%0d ovf_map=%h", nd, n, ovf_map);
        checks++;
        if (mat_c !== ec) begin errors++; $display("FAIL held%0d mat_c got %h want %h", nd, mat_c, ec); end
        checks++;
        if (ovf_map !== eo) begin errors++; $display("FAIL held%0d ovf_map got %h want %h", nd, ovf_map, eo); end
        nd++;
        if (nd == 2) start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (nd !== 2) begin
      errors++; $display("FAIL held done_count got %0d want 2", nd);
      exp_c_q.delete();
      exp_ovf_q.delete();
    end else begin
      checks++;
      if (done_at[1] - done_at[0] !== 27) begin
        errors++; $display("FAIL held period got %0d want 27", done_at[1] - done_at[0]);
      end
    end
    repeat (30) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_ones();
    test_negative();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_start_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
